// File: rtl/parser_pkg.sv
// Shared widths, tag bit indices, payload struct and FSM encoding for the
// header insert path.
package parser_pkg;

  localparam int unsigned DATA_W  = 512;
  localparam int unsigned UNIT_W  = 16;
  localparam int unsigned UNITS   = DATA_W / UNIT_W;
  localparam int unsigned INS_MAX = 8;
  localparam int unsigned TAG_W   = 4;

  localparam int unsigned LU_W  = $clog2(UNITS);
  localparam int unsigned LEN_W = $clog2(INS_MAX + 1);
  localparam int unsigned INS_W = INS_MAX * UNIT_W;
  localparam int unsigned CNT_W = $clog2(UNITS + INS_MAX + 1);

  localparam int unsigned TAG_VALID = 0;
  localparam int unsigned TAG_START = 1;
  localparam int unsigned TAG_LAST  = 2;
  localparam int unsigned TAG_INS   = 3;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } head_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_SHIFT,
    ST_FLUSH
  } state_t;

  // Oversized insert requests are clamped to the largest supported prefix.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(INS_MAX)) ? LEN_W'(INS_MAX) : len;
  endfunction

endpackage

// File: rtl/unit_splice.sv
// Combinational unit splice: {data low (UNITS-L) units, L-unit prefix}, plus
// the L units pushed off the top of the beat.
module unit_splice
  import parser_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [INS_W-1:0]  i_prefix,
  input  logic [LEN_W-1:0]  i_len,
  output logic [DATA_W-1:0] o_data_c,
  output logic [INS_W-1:0]  o_carry_c
);

  logic [DATA_W-1:0] w_cand [INS_MAX+1];
  logic [INS_W-1:0]  w_top  [INS_MAX+1];

  assign w_cand[0] = i_data;
  assign w_top[0]  = '0;

  for (genvar k = 1; k < INS_MAX + 1; k++) begin : g_cand
    assign w_cand[k] = {i_data[DATA_W-k*UNIT_W-1:0], i_prefix[k*UNIT_W-1:0]};
    assign w_top[k]  = INS_W'(i_data[DATA_W-1 -: k*UNIT_W]);
  end

  // One candidate per legal L; anything larger never reaches here.
  always_comb begin
    o_data_c  = w_cand[0];
    o_carry_c = w_top[0];
    for (int k = 0; k < INS_MAX + 1; k++) begin
      if (i_len == LEN_W'(k)) begin
        o_data_c  = w_cand[k];
        o_carry_c = w_top[k];
      end
    end
  end

endmodule

// File: rtl/head_insert.sv
// Re-inserts up to INS_MAX units of rebuilt header in front of a tagged
// packet stream, carrying displaced units across beats and flushing overflow.
module head_insert
  import parser_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [TAG_W+DATA_W-1:0] i_head,
  input  logic [LU_W-1:0]         i_last_units,
  input  logic [INS_W-1:0]        i_ins_data,
  input  logic [LEN_W-1:0]        i_ins_len,
  output logic                    o_ready,
  output logic [TAG_W+DATA_W-1:0] o_head,
  output logic [LU_W-1:0]         o_last_units,
  input  logic                    i_ready,
  output logic                    o_err
);

  state_t             r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic [INS_W-1:0]   r_carry, w_carry_nxt;
  logic [LU_W-1:0]    r_flush_units, w_flush_nxt;
  head_t              r_head, w_head_nxt;
  logic [LU_W-1:0]    r_last_units, w_lu_nxt;
  logic               r_err, w_err_nxt;

  head_t              w_in;
  logic               w_start, w_last, w_load, w_accept, w_len_ovf;
  logic [LEN_W-1:0]   w_req_len, w_len;
  logic [INS_W-1:0]   w_prefix, w_splice_carry;
  logic [CNT_W-1:0]   w_n, w_m;
  logic [DATA_W-1:0]  w_data_msk, w_spliced;

  assign w_in     = i_head;
  assign w_start  = w_in.tag[TAG_START];
  assign w_last   = w_in.tag[TAG_LAST];
  assign w_load   = !r_head.tag[TAG_VALID] || i_ready;
  assign o_ready  = (r_state != ST_FLUSH) && w_load;
  assign w_accept = w_in.tag[TAG_VALID] && o_ready;

  // L comes from the start beat (0 when insert is disabled), else the held value.
  assign w_req_len = w_in.tag[TAG_INS] ? i_ins_len : '0;
  assign w_len_ovf = w_in.tag[TAG_INS] && (i_ins_len > LEN_W'(INS_MAX));
  assign w_len     = w_start ? sat_len(w_req_len) : r_len;
  assign w_prefix  = w_start ? i_ins_data : r_carry;

  assign w_n = (w_last && (i_last_units != '0)) ? CNT_W'(i_last_units) : CNT_W'(UNITS);
  assign w_m = w_n + CNT_W'(w_len);

  // Zero units past the end of the last beat so padding never leaks out.
  always_comb begin
    w_data_msk = '0;
    for (int unsigned u = 0; u < UNITS; u++) begin
      if (CNT_W'(u) < w_n) begin
        w_data_msk[u*UNIT_W +: UNIT_W] = w_in.data[u*UNIT_W +: UNIT_W];
      end
    end
  end

  unit_splice u_splice (
    .i_data    (w_data_msk),
    .i_prefix  (w_prefix),
    .i_len     (w_len),
    .o_data_c  (w_spliced),
    .o_carry_c (w_splice_carry)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_len         <= '0;
      r_carry       <= '0;
      r_flush_units <= '0;
      r_head        <= '0;
      r_last_units  <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_len         <= w_len_nxt;
      r_carry       <= w_carry_nxt;
      r_flush_units <= w_flush_nxt;
      r_head        <= w_head_nxt;
      r_last_units  <= w_lu_nxt;
      r_err         <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_carry_nxt = r_carry;
    w_flush_nxt = r_flush_units;
    w_head_nxt  = r_head;
    w_lu_nxt    = r_last_units;
    w_err_nxt   = 1'b0;

    // A drained output register empties unless refilled below.
    if (w_load) begin
      w_head_nxt = '0;
      w_lu_nxt   = '0;
    end

    if (r_state == ST_FLUSH) begin
      if (w_load) begin
        w_head_nxt.tag[TAG_VALID] = 1'b1;
        w_head_nxt.tag[TAG_LAST]  = 1'b1;
        w_head_nxt.data           = DATA_W'(r_carry);
        w_lu_nxt                  = r_flush_units;
        w_carry_nxt               = '0;
        w_state_nxt               = ST_IDLE;
      end
    end else if (w_accept) begin
      if (!w_start && (r_state == ST_IDLE)) begin
        w_err_nxt = 1'b1;
      end else begin
        if (w_start) begin
          w_len_nxt = w_len;
          w_err_nxt = (r_state != ST_IDLE) || w_len_ovf;
        end
        w_head_nxt.tag[TAG_VALID] = 1'b1;
        w_head_nxt.tag[TAG_START] = w_start;
        w_head_nxt.data           = w_spliced;
        w_carry_nxt               = w_splice_carry;
        if (w_last) begin
          if (w_m <= CNT_W'(UNITS)) begin
            w_head_nxt.tag[TAG_LAST] = 1'b1;
            w_lu_nxt                 = LU_W'(w_m);
            w_carry_nxt              = '0;
            w_state_nxt              = ST_IDLE;
          end else begin
            w_flush_nxt = LU_W'(w_m - CNT_W'(UNITS));
            w_state_nxt = ST_FLUSH;
          end
        end else begin
          w_state_nxt = (w_len == '0) ? ST_PASS : ST_SHIFT;
        end
      end
    end
  end

  assign o_head       = r_head;
  assign o_last_units = r_last_units;
  assign o_err        = r_err;

endmodule
